uart_tx_fifo: RTL

- Buffered UART transmitter that drives the processor top-level serial output `tx`.
- It is the transmit counterpart of the debug serial receive path on `rx`.
- The host side (debug/dump logic) pushes bytes into an internal FIFO.
- The block serialises each byte as an 8-N-1 frame, with optional parity, at a fixed clock-divided baud rate.
- Bytes go out back-to-back with no idle gap while the FIFO is non-empty.

---
 rtl/uart_tx_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8-N-1 UART transmitter with optional parity bit.
// Host pushes bytes into a small circular FIFO; the FSM pops and serialises
// them back-to-back at BAUD_DIV clocks per bit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | line high, waiting for a byte in the FIFO
// START    | start bit (tx=0)
// DATA     | eight data bits, LSB first
// PARITY   | optional parity bit (even/odd over the data byte)
// STOP     | stop bit (tx=1); may chain straight into the next START
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          ODD_PAR   = (PARITY == 2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par;
  logic          tx_q;
  logic          push, pop, bit_end;
  logic [7:0]    head;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign busy    = (state != ST_IDLE) | ~empty;
  assign tx      = tx_q;
  assign head    = mem[rptr[AW-1:0]];
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign push    = wr_en & ~full;
  // Pops only happen when the FSM is ready to begin a new frame.
  assign pop     = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  // FIFO pointers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Frame sequencer: baud counter, shift register and registered tx.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          tx_q     <= 1'b1;
          if (pop) begin
            shift <= head;
            par   <= ^head;
            state <= ST_START;
            tx_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx_q    <= shift[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= HAS_PAR ? ST_PARITY : ST_STOP;
              tx_q  <= HAS_PAR ? (par ^ ODD_PAR) : 1'b1;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            tx_q  <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift <= head;
              par   <= ^head;
              state <= ST_START;
              tx_q  <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx_q  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
